// File: rtl/fls_gen_if.sv
// fls_gen_if: step/seed inputs and sequence outputs of fls_gen (master = driver, slave = generator)
// Signals: i_en step request, i_clr restart, i_d seed, o_f term, o_loaded seeds done, o_ovf sticky overflow, o_cnt term count
interface fls_gen_if #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 8
);
    logic             i_en;
    logic             i_clr;
    logic [WIDTH-1:0] i_d;
    logic [WIDTH-1:0] o_f;
    logic             o_loaded;
    logic             o_ovf;
    logic [CNT_W-1:0] o_cnt;
    modport master (output i_en, i_clr, i_d, input o_f, o_loaded, o_ovf, o_cnt);
    modport slave (input i_en, i_clr, i_d, output o_f, o_loaded, o_ovf, o_cnt);
endinterface

// File: rtl/fls_gen.sv
// fls_gen: order-DEPTH Fibonacci-like sequence generator, one term per rising edge of en
// Ports: clk; rst (async, active-low); bus (fls_gen_if.slave: i_en, i_clr, i_d in; o_f, o_loaded, o_ovf, o_cnt out)
// Macro FLS_SAT_EN: overflowing terms saturate at all-ones instead of wrapping.
module fls_gen #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input logic      clk,
    input logic      rst,
    fls_gen_if.slave bus
);
    typedef enum logic {S_LOAD, S_RUN} state_t;
    state_t                      r_state, w_state_nx;
    logic [DEPTH-1:0][WIDTH-1:0] r_hist;
    logic [WIDTH-1:0]            r_f, w_f_nx, w_next;
    logic [1:0]                  r_idx, w_idx_nx;
    logic [CNT_W-1:0]            r_cnt, w_cnt_nx;
    logic [WIDTH+1:0]            w_sum;
    logic                        r_ovf, w_ovf_nx, r_en_q, r_armed, w_rise, w_big, w_last;
    // r_armed blocks the first edge after reset release so an en already high then only gets sampled
    assign w_rise = bus.i_en & ~r_en_q & r_armed;
    assign w_last = r_idx == 2'(DEPTH - 1);
    // two guard bits hold the sum of up to four WIDTH-bit terms
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < DEPTH; i++) w_sum = w_sum + {2'b00, r_hist[i]};
    end
    assign w_big = |w_sum[WIDTH+1:WIDTH];
`ifdef FLS_SAT_EN
    assign w_next = w_big ? '1 : w_sum[WIDTH-1:0];
`else
    assign w_next = w_sum[WIDTH-1:0];
`endif
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_f_nx     = r_f;
        w_ovf_nx   = r_ovf;
        w_cnt_nx   = r_cnt;
        if (bus.i_clr) begin
            w_state_nx = S_LOAD;
            w_idx_nx   = '0;
            w_f_nx     = '0;
            w_ovf_nx   = 1'b0;
            w_cnt_nx   = '0;
        end else if (w_rise) begin
            w_cnt_nx = &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
            if (r_state == S_LOAD) begin
                w_f_nx     = bus.i_d;
                w_state_nx = w_last ? S_RUN : S_LOAD;
                w_idx_nx   = w_last ? 2'd0 : r_idx + 2'd1;
            end else begin
                w_f_nx   = w_next;
                w_ovf_nx = r_ovf | w_big;
            end
        end
    end
    // the newest history entry always equals the term just presented on f
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_f     <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_en_q  <= 1'b0;
            r_armed <= 1'b0;
            r_hist  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_f     <= w_f_nx;
            r_ovf   <= w_ovf_nx;
            r_cnt   <= w_cnt_nx;
            r_en_q  <= bus.i_en;
            r_armed <= 1'b1;
            if (bus.i_clr)
                r_hist <= '0;
            else if (w_rise)
                r_hist <= {r_hist[DEPTH-2:0], w_f_nx};
        end
    end
    assign bus.o_f      = r_f;
    assign bus.o_loaded = r_state == S_RUN;
    assign bus.o_ovf    = r_ovf;
    assign bus.o_cnt    = r_cnt;
endmodule

// File: tb/tb_fls_gen.sv
// tb_fls_gen: randomized and directed checks of fls_gen (DEPTH=2 and DEPTH=3) against a term-list reference model
module tb_fls_gen;
    localparam int W = 7;
    localparam int C = 8;
`ifdef FLS_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_h[2][4];
    int   m_n[2];
    int   m_f[2];
    int   m_cnt[2];
    int   m_ovf[2];

    fls_gen_if #(.WIDTH(W), .CNT_W(C)) bus2 ();
    fls_gen_if #(.WIDTH(W), .CNT_W(C)) bus3 ();
    fls_gen #(.WIDTH(W), .DEPTH(2), .CNT_W(C)) u_d2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    fls_gen #(.WIDTH(W), .DEPTH(3), .CNT_W(C)) u_d3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] get_f(input int k);
        return k != 0 ? 32'(bus3.o_f) : 32'(bus2.o_f);
    endfunction
    function automatic logic [31:0] get_cnt(input int k);
        return k != 0 ? 32'(bus3.o_cnt) : 32'(bus2.o_cnt);
    endfunction
    function automatic logic [31:0] get_ld(input int k);
        return k != 0 ? 32'(bus3.o_loaded) : 32'(bus2.o_loaded);
    endfunction
    function automatic logic [31:0] get_ovf(input int k);
        return k != 0 ? 32'(bus3.o_ovf) : 32'(bus2.o_ovf);
    endfunction

    task automatic model_clear(input int k);
        for (int i = 0; i < 4; i++) m_h[k][i] = 0;
        m_n[k]   = 0;
        m_f[k]   = 0;
        m_cnt[k] = 0;
        m_ovf[k] = 0;
    endtask

    // first DEPTH steps take seeds; afterwards each term is the sum of the last DEPTH terms
    task automatic model_step(input int k, input int dv);
        int dep, s, nx;
        dep = k != 0 ? 3 : 2;
        if (m_n[k] < dep) begin
            nx = dv;
            m_n[k]++;
        end else begin
            s = 0;
            for (int i = 0; i < dep; i++) s += m_h[k][i];
            nx = s % 128;
            if (s > 127) begin
                m_ovf[k] = 1;
                if (SAT) nx = 127;
            end
        end
        for (int i = 3; i > 0; i--) m_h[k][i] = m_h[k][i-1];
        m_h[k][0] = nx;
        m_f[k]    = nx;
        if (m_cnt[k] < 255) m_cnt[k]++;
    endtask

    task automatic drive(input int k, input logic en, input logic clr, input int dv);
        if (k == 0) begin
            bus2.i_en = en;
            bus2.i_clr = clr;
            bus2.i_d = W'(dv);
        end else begin
            bus3.i_en = en;
            bus3.i_clr = clr;
            bus3.i_d = W'(dv);
        end
    endtask

    task automatic pulse(input int k, input int dv, input int hold);
        @(negedge clk);
        drive(k, 1'b1, 1'b0, dv);
        repeat (hold) @(negedge clk);
        drive(k, 1'b0, 1'b0, dv);
        model_step(k, dv);
    endtask

    task automatic test_reset;
        repeat (7) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            n_cmp += 4;
            if (get_f(k) !== 0) begin n_err++; $display("FAIL reset_f[%0d] got %0d want 0", k, get_f(k)); end
            if (get_ld(k) !== 0) begin n_err++; $display("FAIL reset_loaded[%0d] got %0d want 0", k, get_ld(k)); end
            if (get_ovf(k) !== 0) begin n_err++; $display("FAIL reset_ovf[%0d] got %0d want 0", k, get_ovf(k)); end
            if (get_cnt(k) !== 0) begin n_err++; $display("FAIL reset_cnt[%0d] got %0d want 0", k, get_cnt(k)); end
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_seed_d2;
        int exp_run[3] = '{4, 6, 10};
        for (int i = 0; i < 2; i++) begin
            pulse(0, 2, 1);
            n_cmp++;
            if (get_f(0) !== 2) begin n_err++; $display("FAIL seed_f got %0d want 2", get_f(0)); end
        end
        n_cmp += 2;
        if (get_ld(0) !== 1) begin n_err++; $display("FAIL seed_loaded got %0d want 1", get_ld(0)); end
        if (get_cnt(0) !== 2) begin n_err++; $display("FAIL seed_cnt got %0d want 2", get_cnt(0)); end
        for (int i = 0; i < 3; i++) begin
            pulse(0, 3, 1);
            n_cmp += 2;
            if (get_f(0) !== m_f[0]) begin n_err++; $display("FAIL run_f got %0d want %0d", get_f(0), m_f[0]); end
            if (get_f(0) !== exp_run[i]) begin n_err++; $display("FAIL run_f_abs got %0d want %0d", get_f(0), exp_run[i]); end
        end
    endtask

    task automatic test_hold;
        pulse(0, 3, 20);
        n_cmp += 2;
        if (get_f(0) !== 16) begin n_err++; $display("FAIL hold_f got %0d want 16", get_f(0)); end
        if (get_cnt(0) !== 6) begin n_err++; $display("FAIL hold_cnt got %0d want 6", get_cnt(0)); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            pulse(0, 3, 1);
            n_cmp++;
            if (get_f(0) !== m_f[0]) begin n_err++; $display("FAIL b2b_f got %0d want %0d", get_f(0), m_f[0]); end
        end
        n_cmp += 2;
        if (get_f(0) !== 110) begin n_err++; $display("FAIL b2b_f10 got %0d want 110", get_f(0)); end
        if (get_ovf(0) !== 0) begin n_err++; $display("FAIL b2b_ovf10 got %0d want 0", get_ovf(0)); end
        pulse(0, 3, 1);
        n_cmp += 3;
        if (get_f(0) !== (SAT ? 127 : 50)) begin n_err++; $display("FAIL ovf_f11 got %0d want %0d", get_f(0), SAT ? 127 : 50); end
        if (get_ovf(0) !== 1) begin n_err++; $display("FAIL ovf_flag got %0d want 1", get_ovf(0)); end
        if (get_cnt(0) !== 11) begin n_err++; $display("FAIL ovf_cnt got %0d want 11", get_cnt(0)); end
        pulse(0, 3, 1);
        n_cmp += 2;
        if (get_f(0) !== (SAT ? 127 : 32)) begin n_err++; $display("FAIL ovf_f12 got %0d want %0d", get_f(0), SAT ? 127 : 32); end
        if (get_ovf(0) !== 1) begin n_err++; $display("FAIL ovf_sticky got %0d want 1", get_ovf(0)); end
    endtask

    task automatic test_d3;
        int exp3[5] = '{3, 5, 9, 17, 31};
        for (int i = 0; i < 3; i++) pulse(1, 1, 1);
        n_cmp += 2;
        if (get_f(1) !== 1) begin n_err++; $display("FAIL d3_seed_f got %0d want 1", get_f(1)); end
        if (get_ld(1) !== 1) begin n_err++; $display("FAIL d3_loaded got %0d want 1", get_ld(1)); end
        for (int i = 0; i < 5; i++) begin
            pulse(1, 1, 1);
            n_cmp += 2;
            if (get_f(1) !== exp3[i]) begin n_err++; $display("FAIL d3_f got %0d want %0d", get_f(1), exp3[i]); end
            if (get_f(1) !== m_f[1]) begin n_err++; $display("FAIL d3_model got %0d want %0d", get_f(1), m_f[1]); end
        end
    endtask

    task automatic test_clr;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 9);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 9);
        model_clear(0);
        n_cmp += 4;
        if (get_f(0) !== 0) begin n_err++; $display("FAIL clr_f got %0d want 0", get_f(0)); end
        if (get_ld(0) !== 0) begin n_err++; $display("FAIL clr_loaded got %0d want 0", get_ld(0)); end
        if (get_ovf(0) !== 0) begin n_err++; $display("FAIL clr_ovf got %0d want 0", get_ovf(0)); end
        if (get_cnt(0) !== 0) begin n_err++; $display("FAIL clr_cnt got %0d want 0", get_cnt(0)); end
        pulse(0, 5, 1);
        n_cmp += 2;
        if (get_f(0) !== 5) begin n_err++; $display("FAIL clr_next_f got %0d want 5", get_f(0)); end
        if (get_cnt(0) !== 1) begin n_err++; $display("FAIL clr_next_cnt got %0d want 1", get_cnt(0)); end
    endtask

    task automatic test_async_rst;
        pulse(0, 2, 1);
        for (int i = 0; i < 3; i++) pulse(0, 0, 1);
        n_cmp++;
        if (get_f(0) !== m_f[0]) begin n_err++; $display("FAIL arst_pre_f got %0d want %0d", get_f(0), m_f[0]); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_clear(0);
        model_clear(1);
        n_cmp += 3;
        if (get_f(0) !== 0) begin n_err++; $display("FAIL arst_f got %0d want 0", get_f(0)); end
        if (get_ld(0) !== 0) begin n_err++; $display("FAIL arst_loaded got %0d want 0", get_ld(0)); end
        if (get_ld(1) !== 0) begin n_err++; $display("FAIL arst_loaded3 got %0d want 0", get_ld(1)); end
        drive(0, 1'b1, 1'b0, 9);
        drive(1, 1'b1, 1'b0, 9);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp += 2;
            if (get_cnt(k) !== 0) begin n_err++; $display("FAIL arst_hold_cnt[%0d] got %0d want 0", k, get_cnt(k)); end
            if (get_f(k) !== 0) begin n_err++; $display("FAIL arst_hold_f[%0d] got %0d want 0", k, get_f(k)); end
        end
        drive(0, 1'b0, 1'b0, 9);
        drive(1, 1'b0, 1'b0, 9);
        pulse(0, 6, 1);
        n_cmp += 3;
        if (get_f(0) !== 6) begin n_err++; $display("FAIL arst_step_f got %0d want 6", get_f(0)); end
        if (get_cnt(0) !== 1) begin n_err++; $display("FAIL arst_step_cnt got %0d want 1", get_cnt(0)); end
        if (get_ld(0) !== 0) begin n_err++; $display("FAIL arst_step_loaded got %0d want 0", get_ld(0)); end
    endtask

    task automatic test_saturate;
        while (m_cnt[1] < 255) pulse(1, $urandom_range(0, 127), 1);
        n_cmp++;
        if (get_cnt(1) !== 255) begin n_err++; $display("FAIL sat_cnt got %0d want 255", get_cnt(1)); end
        for (int i = 0; i < 4; i++) begin
            pulse(1, 0, 1);
            n_cmp += 2;
            if (get_cnt(1) !== 255) begin n_err++; $display("FAIL sat_hold_cnt got %0d want 255", get_cnt(1)); end
            if (get_f(1) !== m_f[1]) begin n_err++; $display("FAIL sat_f got %0d want %0d", get_f(1), m_f[1]); end
        end
    endtask

    task automatic test_random;
        int k, dv;
        for (int it = 0; it < 300; it++) begin
            k  = $urandom_range(0, 1);
            dv = $urandom_range(0, 127);
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                drive(k, 1'($urandom_range(0, 1)), 1'b1, dv);
                @(negedge clk);
                drive(k, 1'b0, 1'b0, dv);
                model_clear(k);
            end else begin
                pulse(k, dv, $urandom_range(1, 3));
            end
            n_cmp += 4;
            if (get_f(k) !== m_f[k]) begin n_err++; $display("FAIL rnd_f[%0d] it %0d got %0d want %0d", k, it, get_f(k), m_f[k]); end
            if (get_cnt(k) !== m_cnt[k]) begin n_err++; $display("FAIL rnd_cnt[%0d] it %0d got %0d want %0d", k, it, get_cnt(k), m_cnt[k]); end
            if (get_ovf(k) !== m_ovf[k]) begin n_err++; $display("FAIL rnd_ovf[%0d] it %0d got %0d want %0d", k, it, get_ovf(k), m_ovf[k]); end
            if (get_ld(k) !== 32'(m_n[k] == (k != 0 ? 3 : 2))) begin n_err++; $display("FAIL rnd_loaded[%0d] it %0d got %0d", k, it, get_ld(k)); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0);
        test_reset;
        test_seed_d2;
        test_hold;
        test_back_to_back;
        test_d3;
        test_clr;
        test_async_rst;
        test_saturate;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
